// File: rtl/chip8_core.sv
// chip8_core: CHIP-8 interpreter core fetching big-endian opcodes from ram1 port A.
// Optional macro CHIP8_MEMOPS_EN enables FX33/FX55/FX65 and the MEM state;
// without it those opcodes are NOPs and ram_data/ram_wren are tied low.
// ram_q is expected to reflect the byte at ram_address one clock after the
// address register is loaded, so every read is issued one state before it is latched.
module chip8_core #(
    parameter logic [11:0] PC_RESET = 12'h200
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  ram_q,
    output logic [11:0] ram_address,
    output logic [7:0]  ram_data,
    output logic        ram_wren,
    output logic [7:0]  LED
);

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 12;

    typedef enum logic [2:0] {
        FETCH1 = 3'd0,
        FETCH2 = 3'd1,
        FETCH3 = 3'd2,
        EXEC   = 3'd3
`ifdef CHIP8_MEMOPS_EN
        ,
        MEM    = 3'd4
`endif
    } state_t;

    state_t         state, state_n;
    logic [DW-1:0]  v [16];
    logic [DW-1:0]  v_n [16];
    logic [AW-1:0]  stack [16];
    logic [AW-1:0]  i_reg, i_n;
    logic [AW-1:0]  pc, pc_n;
    logic [3:0]     sp, sp_n;
    logic [15:0]    opcode, opcode_n;
    logic [AW-1:0]  addr_n;
    logic           stack_we;

    logic [3:0]     x, y, n;
    logic [7:0]     nn;
    logic [11:0]    nnn;
    logic [DW-1:0]  vx, vy;
    logic [8:0]     add9;
    logic [3:0]     sp_dec;

`ifdef CHIP8_MEMOPS_EN
    logic [DW-1:0]  data_n;
    logic           wren_n;
    logic [4:0]     cnt, cnt_n;
    logic [3:0]     cnt_inc, cnt_dec;
    logic [DW-1:0]  bcd_h, bcd_t, bcd_o;
`endif

    // Opcode field decode and shared arithmetic
    assign x      = opcode[11:8];
    assign y      = opcode[7:4];
    assign n      = opcode[3:0];
    assign nn     = opcode[7:0];
    assign nnn    = opcode[11:0];
    assign vx     = v[x];
    assign vy     = v[y];
    assign add9   = {1'b0, vx} + {1'b0, vy};
    assign sp_dec = sp - 4'd1;
    assign LED    = v[0];

`ifdef CHIP8_MEMOPS_EN
    assign cnt_inc = cnt[3:0] + 4'd1;
    assign cnt_dec = 4'(cnt - 5'd1);
    assign bcd_h   = vx / 8'd100;
    assign bcd_t   = (vx / 8'd10) % 8'd10;
    assign bcd_o   = vx % 8'd10;
`else
    assign ram_data = '0;
    assign ram_wren = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= FETCH1;
            for (int k = 0; k < 16; k++) begin
                v[k]     <= '0;
                stack[k] <= '0;
            end
            i_reg       <= '0;
            pc          <= PC_RESET;
            sp          <= '0;
            opcode      <= '0;
            ram_address <= '0;
`ifdef CHIP8_MEMOPS_EN
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            cnt         <= '0;
`endif
        end else begin
            state       <= state_n;
            v           <= v_n;
            i_reg       <= i_n;
            pc          <= pc_n;
            sp          <= sp_n;
            opcode      <= opcode_n;
            ram_address <= addr_n;
            if (stack_we) begin
                stack[sp] <= pc + 12'd2;
            end
`ifdef CHIP8_MEMOPS_EN
            ram_data    <= data_n;
            ram_wren    <= wren_n;
            cnt         <= cnt_n;
`endif
        end
    end

    // Next-state, execute and memory sequencing
    always_comb begin
        state_n  = state;
        v_n      = v;
        i_n      = i_reg;
        pc_n     = pc;
        sp_n     = sp;
        opcode_n = opcode;
        addr_n   = ram_address;
        stack_we = 1'b0;
`ifdef CHIP8_MEMOPS_EN
        data_n   = ram_data;
        wren_n   = 1'b0;
        cnt_n    = cnt;
`endif
        case (state)
            FETCH1: begin
                addr_n  = pc;
                state_n = FETCH2;
            end
            FETCH2: begin
                addr_n          = pc + 12'd1;
                opcode_n[15:8]  = ram_q;
                state_n         = FETCH3;
            end
            FETCH3: begin
                opcode_n[7:0] = ram_q;
                state_n       = EXEC;
            end
            EXEC: begin
                state_n = FETCH1;
                pc_n    = pc + 12'd2;
                case (opcode[15:12])
                    4'h0: begin
                        if (opcode == 16'h00EE) begin
                            sp_n = sp_dec;
                            pc_n = stack[sp_dec];
                        end
                    end
                    4'h1: pc_n = nnn;
                    4'h2: begin
                        stack_we = 1'b1;
                        sp_n     = sp + 4'd1;
                        pc_n     = nnn;
                    end
                    4'h3: if (vx == nn) pc_n = pc + 12'd4;
                    4'h4: if (vx != nn) pc_n = pc + 12'd4;
                    4'h5: if (n == 4'h0 && vx == vy) pc_n = pc + 12'd4;
                    4'h6: v_n[x] = nn;
                    4'h7: v_n[x] = vx + nn;
                    4'h8: begin
                        // Flag is written after the result so VF as destination keeps the flag
                        case (n)
                            4'h0: v_n[x] = vy;
                            4'h1: v_n[x] = vx | vy;
                            4'h2: v_n[x] = vx & vy;
                            4'h3: v_n[x] = vx ^ vy;
                            4'h4: begin
                                v_n[x]    = add9[7:0];
                                v_n[4'hF] = 8'(add9[8]);
                            end
                            4'h5: begin
                                v_n[x]    = vx - vy;
                                v_n[4'hF] = 8'(vx >= vy);
                            end
                            4'h6: begin
                                v_n[x]    = vx >> 1;
                                v_n[4'hF] = 8'(vx[0]);
                            end
                            4'h7: begin
                                v_n[x]    = vy - vx;
                                v_n[4'hF] = 8'(vy >= vx);
                            end
                            4'hE: begin
                                v_n[x]    = vx << 1;
                                v_n[4'hF] = 8'(vx[7]);
                            end
                            default: ;
                        endcase
                    end
                    4'h9: if (n == 4'h0 && vx != vy) pc_n = pc + 12'd4;
                    4'hA: i_n  = nnn;
                    4'hB: pc_n = nnn + 12'(v[0]);
                    4'hF: begin
                        case (nn)
                            8'h1E: i_n = i_reg + 12'(vx);
`ifdef CHIP8_MEMOPS_EN
                            8'h33: begin
                                addr_n  = i_reg;
                                data_n  = bcd_h;
                                wren_n  = 1'b1;
                                cnt_n   = '0;
                                state_n = MEM;
                            end
                            8'h55: begin
                                addr_n  = i_reg;
                                data_n  = v[0];
                                wren_n  = 1'b1;
                                cnt_n   = '0;
                                state_n = MEM;
                            end
                            8'h65: begin
                                cnt_n   = '0;
                                state_n = MEM;
                            end
`endif
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
`ifdef CHIP8_MEMOPS_EN
            MEM: begin
                case (nn)
                    8'h33: begin
                        if (cnt == 5'd2) begin
                            state_n = FETCH1;
                        end else begin
                            addr_n = i_reg + 12'(cnt) + 12'd1;
                            data_n = (cnt == 5'd0) ? bcd_t : bcd_o;
                            wren_n = 1'b1;
                            cnt_n  = cnt + 5'd1;
                        end
                    end
                    8'h55: begin
                        if (cnt == {1'b0, x}) begin
                            state_n = FETCH1;
                        end else begin
                            addr_n = i_reg + 12'(cnt) + 12'd1;
                            data_n = v[cnt_inc];
                            wren_n = 1'b1;
                            cnt_n  = cnt + 5'd1;
                        end
                    end
                    8'h65: begin
                        // Issue I+cnt now, capture the byte issued in the previous cycle
                        if (cnt <= {1'b0, x}) begin
                            addr_n = i_reg + 12'(cnt);
                        end
                        if (cnt != 5'd0) begin
                            v_n[cnt_dec] = ram_q;
                        end
                        if (cnt == {1'b0, x} + 5'd1) begin
                            state_n = FETCH1;
                        end else begin
                            cnt_n = cnt + 5'd1;
                        end
                    end
                    default: state_n = FETCH1;
                endcase
            end
`endif
            default: state_n = FETCH1;
        endcase
    end

endmodule

// File: tb/tb_chip8_core.sv
// tb_chip8_core: directed program tests for chip8_core with a behavioural 4 KiB RAM.
module tb_chip8_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  ram_q;
    logic [11:0] ram_address;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic [7:0]  led;

    logic [7:0]  mem [4096];
    logic        ld_clr = 1'b0;
    logic        ld_en = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [7:0]  ld_val = '0;

    int checks = 0;
    int errors = 0;

    chip8_core dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .ram_q       (ram_q),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .LED         (led)
    );

    always #5 clk = ~clk;

    // RAM: read data follows the registered address; writes and bench loads on the clock edge
    assign ram_q = mem[ram_address];
    always @(posedge clk) begin
        if (ld_clr) begin
            for (int k = 0; k < 4096; k++) mem[k] <= 8'h00;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_val;
        end else if (ram_wren) begin
            mem[ram_address] <= ram_data;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_test();
        reset = 1'b1;
        @(posedge clk); #1;
        ld_clr = 1'b1;
        @(posedge clk); #1;
        ld_clr = 1'b0;
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] hi, input logic [7:0] lo);
        ld_en = 1'b1;
        ld_addr = a;       ld_val = hi;
        @(posedge clk); #1;
        ld_addr = a + 12'd1; ld_val = lo;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // Reset values and fetch timing
        begin_test();
        poke(12'h200, 8'h60, 8'h58);
        chk("rst_led", 16'(led), 16'h0000);
        chk("rst_addr", 16'(ram_address), 16'h0000);
        chk("rst_wren", 16'(ram_wren), 16'h0000);
        release_reset();
        chk("post_rst_led", 16'(led), 16'h0000);
        run(1); chk("fetch1_addr", 16'(ram_address), 16'h0200);
        run(1); chk("fetch2_addr", 16'(ram_address), 16'h0201);
        run(1); chk("led_e3", 16'(led), 16'h0000);
        run(1); chk("led_e4", 16'(led), 16'h0058);

        // 7XNN wraps and leaves VF alone
        begin_test();
        poke(12'h200, 8'h60, 8'hFF);
        poke(12'h202, 8'h70, 8'h02);
        poke(12'h204, 8'h80, 8'hF0);
        release_reset();
        run(8);  chk("add_imm_v0", 16'(led), 16'h0001);
        run(4);  chk("add_imm_vf", 16'(led), 16'h0000);

        // 8XY4 carry, and VF destination keeps the flag
        begin_test();
        poke(12'h200, 8'h60, 8'hFF);
        poke(12'h202, 8'h61, 8'h02);
        poke(12'h204, 8'h80, 8'h14);
        poke(12'h206, 8'h80, 8'hF0);
        poke(12'h208, 8'h6F, 8'h80);
        poke(12'h20A, 8'h8F, 8'hF4);
        poke(12'h20C, 8'h80, 8'hF0);
        release_reset();
        run(12); chk("add_v0", 16'(led), 16'h0001);
        run(4);  chk("add_carry", 16'(led), 16'h0001);
        run(12); chk("vf_flag_wins", 16'(led), 16'h0001);

        // Call and return
        begin_test();
        poke(12'h200, 8'h22, 8'h06);
        poke(12'h202, 8'h60, 8'hAA);
        poke(12'h206, 8'h00, 8'hEE);
        release_reset();
        run(4);  chk("call_sp", 16'(dut.sp), 16'h0001);
        run(1);  chk("call_target", 16'(ram_address), 16'h0206);
        run(3);  chk("ret_sp", 16'(dut.sp), 16'h0000);
        run(1);  chk("ret_target", 16'(ram_address), 16'h0202);
        run(3);  chk("after_ret_led", 16'(led), 16'h00AA);

        // Skips: 3XNN taken, 4XNN not, 5XY0 not, 9XY0 taken
        begin_test();
        poke(12'h200, 8'h30, 8'h00);
        poke(12'h204, 8'h40, 8'h00);
        poke(12'h206, 8'h60, 8'h07);
        poke(12'h208, 8'h50, 8'h10);
        poke(12'h20A, 8'h90, 8'h10);
        release_reset();
        run(5);  chk("skip_eq", 16'(ram_address), 16'h0204);
        run(4);  chk("noskip_ne", 16'(ram_address), 16'h0206);
        run(3);  chk("skip_led", 16'(led), 16'h0007);
        run(1);  chk("fetch_208", 16'(ram_address), 16'h0208);
        run(4);  chk("noskip_vv", 16'(ram_address), 16'h020A);
        run(4);  chk("skip_vv_ne", 16'(ram_address), 16'h020E);

        // ALU sub, shifts, logic ops
        begin_test();
        poke(12'h200, 8'h60, 8'h05);
        poke(12'h202, 8'h61, 8'h07);
        poke(12'h204, 8'h80, 8'h15);
        poke(12'h206, 8'h80, 8'h16);
        poke(12'h208, 8'h80, 8'h1E);
        poke(12'h20A, 8'h80, 8'h0E);
        poke(12'h20C, 8'h80, 8'hF0);
        poke(12'h20E, 8'h80, 8'h13);
        poke(12'h210, 8'h62, 8'h09);
        poke(12'h212, 8'h80, 8'h21);
        poke(12'h214, 8'h80, 8'h17);
        poke(12'h216, 8'h80, 8'hF0);
        release_reset();
        run(12); chk("sub", 16'(led), 16'h00FE);
        run(4);  chk("shr", 16'(led), 16'h007F);
        run(4);  chk("shl", 16'(led), 16'h00FE);
        run(4);  chk("shl2", 16'(led), 16'h00FC);
        run(4);  chk("shl_flag", 16'(led), 16'h0001);
        run(4);  chk("xor", 16'(led), 16'h0006);
        run(8);  chk("or", 16'(led), 16'h000F);
        run(4);  chk("subn", 16'(led), 16'h00F8);
        run(4);  chk("subn_flag", 16'(led), 16'h0000);

        // BNNN and 1NNN
        begin_test();
        poke(12'h200, 8'h60, 8'h04);
        poke(12'h202, 8'hB3, 8'h00);
        poke(12'h304, 8'h12, 8'h00);
        release_reset();
        run(9);  chk("jump_v0", 16'(ram_address), 16'h0304);
        run(4);  chk("jump", 16'(ram_address), 16'h0200);

`ifdef CHIP8_MEMOPS_EN
        // Reset in the middle of FX33 drops the write enable at once
        begin_test();
        poke(12'h200, 8'h60, 8'hFE);
        poke(12'h202, 8'hA3, 8'h00);
        poke(12'h204, 8'hF0, 8'h33);
        release_reset();
        run(12); chk("bcd_wren0", 16'(ram_wren), 16'h0001);
        chk("bcd_addr0", 16'(ram_address), 16'h0300);
        chk("bcd_data0", 16'(ram_data), 16'h0002);
        run(1);
        reset = 1'b1;
        #1;
        chk("abort_wren", 16'(ram_wren), 16'h0000);
        run(3);
        chk("abort_mem300", 16'(mem[12'h300]), 16'h0002);
        chk("abort_mem301", 16'(mem[12'h301]), 16'h0000);

        // FX33, FX65, FX55 end to end
        begin_test();
        poke(12'h200, 8'h60, 8'hFE);
        poke(12'h202, 8'hA3, 8'h00);
        poke(12'h204, 8'hF0, 8'h33);
        poke(12'h206, 8'h63, 8'h0A);
        poke(12'h208, 8'hA3, 8'h00);
        poke(12'h20A, 8'hF0, 8'h65);
        poke(12'h20C, 8'h61, 8'h77);
        poke(12'h20E, 8'hF1, 8'h55);
        poke(12'h210, 8'h12, 8'h10);
        release_reset();
        run(13); chk("bcd_addr1", 16'(ram_address), 16'h0301);
        chk("bcd_data1", 16'(ram_data), 16'h0005);
        run(1);  chk("bcd_data2", 16'(ram_data), 16'h0004);
        chk("bcd_wren2", 16'(ram_wren), 16'h0001);
        run(1);  chk("bcd_done_wren", 16'(ram_wren), 16'h0000);
        chk("bcd_h", 16'(mem[12'h300]), 16'h0002);
        chk("bcd_t", 16'(mem[12'h301]), 16'h0005);
        chk("bcd_o", 16'(mem[12'h302]), 16'h0004);
        run(13); chk("ld_pending", 16'(led), 16'h00FE);
        run(1);  chk("ld_v0", 16'(led), 16'h0002);
        run(8);  chk("st_data0", 16'(ram_data), 16'h0002);
        chk("st_wren0", 16'(ram_wren), 16'h0001);
        run(2);  chk("st_done_wren", 16'(ram_wren), 16'h0000);
        chk("st_mem300", 16'(mem[12'h300]), 16'h0002);
        chk("st_mem301", 16'(mem[12'h301]), 16'h0077);
`else
        // Memory opcodes decode as NOPs
        begin_test();
        poke(12'h200, 8'h60, 8'hFE);
        poke(12'h202, 8'hA3, 8'h00);
        poke(12'h204, 8'hF0, 8'h33);
        poke(12'h206, 8'h60, 8'h11);
        release_reset();
        run(12); chk("nop_wren", 16'(ram_wren), 16'h0000);
        run(1);  chk("nop_next", 16'(ram_address), 16'h0206);
        run(3);  chk("nop_led", 16'(led), 16'h0011);
        chk("nop_mem300", 16'(mem[12'h300]), 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
